// File: rtl/alu_resp_unit.sv
// ============================================================================
// Module      : alu_resp_unit
// Description : Single-cycle ALU feeding a DEPTH-entry in-order result FIFO
//               with a wrapping sequence tag. Macro ALU_RESP_OVF_EN adds a
//               signed-overflow flag to each buffered result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_resp_unit #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_sel,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_out,
    output logic             resp_zero,
`ifdef ALU_RESP_OVF_EN
    output logic             resp_ovf,
`endif
    output logic [TAG_W-1:0] resp_tag
);

    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ALU_RESP_OVF_EN
    localparam int c_entry_w = 32 + 1 + TAG_W + 1;
`else
    localparam int c_entry_w = 32 + 1 + TAG_W;
`endif
    localparam logic [c_addr_w:0]   c_depth   = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_cnt_one = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);
    localparam logic [TAG_W-1:0]    c_tag_one = TAG_W'(1);

    logic [c_entry_w-1:0] mem_q [DEPTH];
    logic [c_entry_w-1:0] entry_d;
    logic [c_entry_w-1:0] head;
    logic [c_addr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_addr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_addr_w:0]    count_q, count_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [31:0]          sum, diff, result;
    logic                 ovf;
    logic                 push, pop;

    // Outputs are gated by rst_n/occupancy so they read zero during reset
    // without needing to clear the storage array.
    assign req_ready  = rst_n && (count_q < c_depth);
    assign resp_valid = (count_q != '0);
    assign push       = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready;

    always_comb begin
        sum    = req_a + req_b;
        diff   = req_a - req_b;
        result = '0;
        ovf    = 1'b0;
        case (req_sel)
            3'b000: result = req_a & req_b;
            3'b001: result = req_a | req_b;
            3'b100: begin
                result = sum;
                ovf    = (req_a[31] == req_b[31]) && (sum[31] != req_a[31]);
            end
            3'b101: begin
                result = diff;
                ovf    = (req_a[31] != req_b[31]) && (diff[31] != req_a[31]);
            end
            3'b110: result = req_a ^ req_b;
            default: result = '0;
        endcase
`ifdef ALU_RESP_OVF_EN
        entry_d = {ovf, tag_q, (result == '0), result};
`else
        entry_d = {tag_q, (result == '0), result};
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tag_d    = tag_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
            tag_d    = tag_q + c_tag_one;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    always_comb begin
        head      = resp_valid ? mem_q[rd_ptr_q] : '0;
        resp_out  = head[31:0];
        resp_zero = head[32];
        resp_tag  = head[33 +: TAG_W];
`ifdef ALU_RESP_OVF_EN
        resp_ovf  = head[33 + TAG_W];
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_resp_unit.sv
// ============================================================================
// Module      : tb_alu_resp_unit
// Description : Directed self-checking bench for alu_resp_unit (DEPTH=2, TAG_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_resp_unit;

    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [2:0]       req_sel;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_out;
    logic             resp_zero;
    logic [TAG_W-1:0] resp_tag;
`ifdef ALU_RESP_OVF_EN
    logic             resp_ovf;
`endif

    int total;
    int bad;

    alu_resp_unit #(.DEPTH(2), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_zero  (resp_zero),
`ifdef ALU_RESP_OVF_EN
        .resp_ovf   (resp_ovf),
`endif
        .resp_tag   (resp_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request into an empty FIFO, check the head next cycle, then drain it.
    task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] sel, input logic [31:0] eo, input logic ez,
                          input logic [TAG_W-1:0] et, input logic eovf);
        @(negedge clk);
        req_a = a; req_b = b; req_sel = sel; req_valid = 1'b1; resp_ready = 1'b0;
        chk_val({nm, "_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk_val({nm, "_valid"}, 32'(resp_valid), 32'd1);
        chk_val({nm, "_out"}, resp_out, eo);
        chk_val({nm, "_zero"}, 32'(resp_zero), 32'(ez));
        chk_val({nm, "_tag"}, 32'(resp_tag), 32'(et));
`ifdef ALU_RESP_OVF_EN
        chk_val({nm, "_ovf"}, 32'(resp_ovf), 32'(eovf));
`else
        if (eovf === 1'bx) chk_val({nm, "_ovfx"}, 32'd0, 32'd1);
`endif
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk_val({nm, "_drain"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sel = '0;

        #3;
        chk_val("rst_req_ready", 32'(req_ready), 32'd0);
        chk_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk_val("rst_resp_out", resp_out, 32'd0);
        chk_val("rst_resp_zero", 32'(resp_zero), 32'd0);
        chk_val("rst_resp_tag", 32'(resp_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_val("post_rst_ready", 32'(req_ready), 32'd1);

        single("add_2_6",   32'd2,          32'd6,          3'b100, 32'd8,          1'b0, 4'd0, 1'b0);
        single("add_ovf",   32'h7FFFFFFF,   32'h7FFFFFFF,   3'b100, 32'hFFFFFFFE,   1'b0, 4'd1, 1'b1);
        single("sub_zero",  32'd2,          32'd2,          3'b101, 32'd0,          1'b1, 4'd2, 1'b0);
        single("sub_neg",   32'd0,          32'h7FFFFFFF,   3'b101, 32'h80000001,   1'b0, 4'd3, 1'b0);
        single("and",       32'h000000AA,   32'h0000FFFF,   3'b000, 32'h000000AA,   1'b0, 4'd4, 1'b0);
        single("or",        32'h000000AA,   32'h0000FFFF,   3'b001, 32'h0000FFFF,   1'b0, 4'd5, 1'b0);
        single("xor",       32'h000000AA,   32'h0000FFFF,   3'b110, 32'h0000FF55,   1'b0, 4'd6, 1'b0);
        single("sel111",    32'h000000AA,   32'h0000FFFF,   3'b111, 32'd0,          1'b1, 4'd7, 1'b0);
        single("sel010",    32'h000000AA,   32'h0000FFFF,   3'b010, 32'd0,          1'b1, 4'd8, 1'b0);
        single("sub_ovf",   32'h80000000,   32'd1,          3'b101, 32'h7FFFFFFF,   1'b0, 4'd9, 1'b1);

        // Backpressure: fill the two entries, hold a third request while full.
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b1; req_sel = 3'b100;
        req_a = 32'd1; req_b = 32'd1;
        @(negedge clk);
        chk_val("bp_ready_1", 32'(req_ready), 32'd1);
        req_a = 32'd2; req_b = 32'd2;
        @(negedge clk);
        chk_val("bp_full_ready", 32'(req_ready), 32'd0);
        req_a = 32'd3; req_b = 32'd3;
        chk_val("bp_head_out", resp_out, 32'd2);
        chk_val("bp_head_tag", 32'(resp_tag), 32'd10);
        @(negedge clk);
        chk_val("bp_stall_out", resp_out, 32'd2);
        chk_val("bp_stall_tag", 32'(resp_tag), 32'd10);
        chk_val("bp_stall_ready", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk_val("bp_pop1_out", resp_out, 32'd4);
        chk_val("bp_pop1_tag", 32'(resp_tag), 32'd11);
        chk_val("bp_pop1_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk_val("bp_pop2_out", resp_out, 32'd6);
        chk_val("bp_pop2_tag", 32'(resp_tag), 32'd12);
        chk_val("bp_pop2_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        resp_ready = 1'b0;
        chk_val("bp_empty", 32'(resp_valid), 32'd0);

        // Tag wraps from 15 back to 0.
        for (int i = 13; i < 16; i++) begin
            single("wrap_pre", 32'(i), 32'd0, 3'b100, 32'(i), 1'b0, TAG_W'(i), 1'b0);
        end
        single("wrap_zero", 32'd9, 32'd1, 3'b100, 32'd10, 1'b0, 4'd0, 1'b0);

        // Asynchronous reset with two entries buffered.
        @(negedge clk);
        req_valid = 1'b1; req_sel = 3'b001; req_a = 32'h11; req_b = 32'h0;
        @(negedge clk);
        req_a = 32'h22;
        @(negedge clk);
        req_valid = 1'b0;
        chk_val("mid_valid", 32'(resp_valid), 32'd1);
        chk_val("mid_full", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("arst_valid", 32'(resp_valid), 32'd0);
        chk_val("arst_ready", 32'(req_ready), 32'd0);
        chk_val("arst_out", resp_out, 32'd0);
        chk_val("arst_tag", 32'(resp_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_val("arel_ready", 32'(req_ready), 32'd1);
        chk_val("arel_valid", 32'(resp_valid), 32'd0);
        single("after_rst", 32'd5, 32'd5, 3'b100, 32'd10, 1'b0, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_resp_unit.md
ALU_RESP_UNIT -- requirements
Module: alu_resp_unit

Interface
REQ-001 Parameter DEPTH, default 2, result-buffer entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TAG_W, default 4, width of the response sequence tag.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  unit can accept a request this cycle.
REQ-007 Port req_a, req_b  input  32 each  operands.
REQ-008 Port req_sel  input  3  operation select.
REQ-009 Port resp_valid  output  1  head result present.
REQ-010 Port resp_ready  input  1  consumer accepts head result.
REQ-011 Port resp_out  output  32  head result.
REQ-012 Port resp_zero  output  1  head result equals zero.
REQ-013 Port resp_tag  output  TAG_W  sequence number of head result.
REQ-014 Port resp_ovf  output  1  signed-overflow flag of head result; present only per REQ-031.

Function
REQ-015 Request accepted on an edge where req_valid and req_ready are both 1; response consumed on an edge where resp_valid and resp_ready are both 1.
REQ-016 req_sel encoding: 000 AND, 001 OR, 100 ADD, 101 SUB (a-b), 110 XOR; 010, 011 and 111 SHALL yield result 0.
REQ-017 ADD/SUB SHALL be 32-bit modulo; carry discarded.
REQ-018 resp_zero SHALL be 1 exactly when the stored 32-bit result is 0.
REQ-019 Result, zero flag and tag SHALL be computed from the request at acceptance and written into a DEPTH-entry FIFO in the same edge.
REQ-020 Latency: resp_valid SHALL be 1 in the cycle after acceptance when the FIFO was empty; no combinational path from req_* to resp_*.
REQ-021 req_ready SHALL be 1 exactly when the FIFO holds fewer than DEPTH entries; it SHALL NOT depend on resp_ready.
REQ-022 Full FIFO: req_ready=0, and a request held while full SHALL be accepted on the first edge after a pop frees an entry.
REQ-023 Simultaneous push and pop SHALL leave the occupancy unchanged and preserve order.
REQ-024 resp_valid SHALL be 1 exactly when the FIFO is non-empty; resp_out, resp_zero, resp_tag and resp_ovf SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-025 Tag counter SHALL increment by 1 per accepted request and wrap from 2^TAG_W-1 to 0; the first request after reset SHALL carry tag 0.
REQ-026 Responses SHALL leave in acceptance order; none are dropped or duplicated.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, clear the FIFO, the pointers and the tag counter.
REQ-028 During reset: req_ready=0, resp_valid=0, resp_out=0, resp_zero=0, resp_tag=0, resp_ovf=0.
REQ-029 Reset mid-operation SHALL discard all buffered results; req_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-030 Macro ALU_RESP_OVF_EN selects whether the overflow flag is compiled in.
REQ-031 With ALU_RESP_OVF_EN defined: the resp_ovf port exists and each FIFO entry stores one overflow bit.
- ADD: overflow set when both operands have the same sign and the result sign differs.
- SUB: overflow set when the operand signs differ and the result sign differs from req_a.
- All other operations: overflow 0.
REQ-032 Without ALU_RESP_OVF_EN: no resp_ovf port and no overflow storage; all other behaviour identical.

Verification
REQ-033 After reset, ADD a=2, b=6 with resp_ready=1 -> next cycle resp_valid=1, resp_out=8, resp_zero=0, resp_tag=0.
REQ-034 ADD a=32'h7FFFFFFF, b=32'h7FFFFFFF -> resp_out=32'hFFFFFFFE; resp_ovf=1 when ALU_RESP_OVF_EN is defined.
REQ-035 SUB a=2, b=2 -> resp_out=0, resp_zero=1; SUB a=0, b=32'h7FFFFFFF -> resp_out=32'h80000001.
REQ-036 a=32'h000000AA, b=32'h0000FFFF with sel 000/001/110 -> 32'h000000AA, 32'h0000FFFF, 32'h0000FF55; sel 111 -> 0, resp_zero=1.
REQ-037 resp_ready=0 with 3 back-to-back requests, DEPTH=2 -> req_ready=0 after 2 accepts; raise resp_ready -> tags 0,1,2 delivered in order; outputs stable while stalled.
REQ-038 Pull rst_n low with 2 entries buffered -> resp_valid=0 immediately; after release the next request gets tag 0.
